linear_dot_accumulator: RTL and testbench
=========================================

LINEAR_DOT_ACCUMULATOR -- requirements
Module: linear_dot_accumulator

Interface
REQ-001 The block SHALL have parameter DATA_IN_PRECISION_0, default 16, meaning activation element total width (signed).
REQ-002 The block SHALL have parameter DATA_IN_PRECISION_1, default 3, meaning activation fraction bits.
REQ-003 The block SHALL have parameter WEIGHT_PRECISION_0, default 16, meaning weight element total width (signed).
REQ-004 The block SHALL have parameter WEIGHT_PRECISION_1, default 3, meaning weight fraction bits.
REQ-005 The block SHALL have parameter PARALLELISM, default 4, meaning elements per beat on both input streams.
REQ-006 The block SHALL have parameter IN_DEPTH, default 8, meaning beats accumulated per output; legal range is 1 or more.
REQ-007 The block SHALL have parameter DATA_OUT_PRECISION_0, default DATA_IN_PRECISION_0+WEIGHT_PRECISION_0+$clog2(PARALLELISM*IN_DEPTH), meaning output width.
REQ-008 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state is on its rising edge.
REQ-009 The block SHALL have port rst, input, 1 bit, meaning reset; it is asynchronous and active-low.
REQ-010 The block SHALL have port data_in, input, array of PARALLELISM elements of DATA_IN_PRECISION_0 bits, meaning the activation vector.
REQ-011 The block SHALL have ports data_in_valid (input, 1 bit) and data_in_ready (output, 1 bit), meaning the activation handshake.
REQ-012 The block SHALL have port weight, input, array of PARALLELISM elements of WEIGHT_PRECISION_0 bits, meaning the weight vector from the weight source stage.
REQ-013 The block SHALL have ports weight_valid (input, 1 bit) and weight_ready (output, 1 bit), meaning the weight handshake.
REQ-014 The block SHALL have port data_out, output, DATA_OUT_PRECISION_0 bits signed, meaning the accumulated dot product; it has DATA_IN_PRECISION_1+WEIGHT_PRECISION_1 fraction bits.
REQ-015 The block SHALL have ports data_out_valid (output, 1 bit) and data_out_ready (input, 1 bit), meaning the result handshake.

Function
REQ-016 A beat SHALL be consumed only when data_in_valid, weight_valid and the internal accept condition are all high; both streams are consumed together, never one alone.
REQ-017 data_in_ready SHALL equal weight_valid AND accept; weight_ready SHALL equal data_in_valid AND accept.
REQ-018 accept SHALL equal NOT data_out_valid OR data_out_ready.
REQ-019 Each consumed beat SHALL add the signed sum of PARALLELISM elementwise products to the accumulator, computed at full internal width with no intermediate truncation.
REQ-020 A beat counter SHALL run from 0 to IN_DEPTH-1 and advance only on consumed beats.
REQ-021 The counter SHALL wrap to 0 on the last beat; on that beat the accumulator SHALL also clear to 0.
REQ-022 On the last beat, the final sum (accumulator plus the current beat) SHALL be registered into data_out, and data_out_valid SHALL be set on the next cycle.
REQ-023 Latency SHALL be one clock from the last consumed beat to data_out_valid.
REQ-024 data_out and data_out_valid SHALL hold stable while data_out_valid=1 and data_out_ready=0.
REQ-025 While the output is stalled, no input beat SHALL be consumed.
REQ-026 data_out_valid SHALL clear after a cycle with data_out_valid=1 and data_out_ready=1, unless a new last beat is consumed in that same cycle; in that case data_out_valid stays 1 and data_out updates.
REQ-027 With IN_DEPTH=1, every consumed beat SHALL produce an output.
REQ-028 Sustained throughput SHALL be one beat per cycle when all valids and data_out_ready are held high.

Reset
REQ-029 When rst=0, the block SHALL asynchronously clear the counter, the accumulator, data_out and data_out_valid to 0.
REQ-030 While rst=0, data_in_ready and weight_ready SHALL be 0.
REQ-031 A reset asserted mid-accumulation SHALL discard the partial sum; the first beat consumed after release is beat 0.

Configuration
REQ-032 Macro LINEAR_DOT_ACCUMULATOR_SATURATE_EN, when defined, SHALL clamp the registered result to the signed DATA_OUT_PRECISION_0 range (max 2^(W-1)-1, min -2^(W-1)).
REQ-033 When LINEAR_DOT_ACCUMULATOR_SATURATE_EN is undefined, the result SHALL be truncated to its low DATA_OUT_PRECISION_0 bits (two's-complement wrap).
REQ-034 Without LINEAR_DOT_ACCUMULATOR_SATURATE_EN and with DATA_OUT_PRECISION_0 at default, the saturate and truncate behaviours SHALL be identical.

Verification
REQ-035 Bench SHALL cover defaults with all data=1 and weights=2, all valids and ready high: data_out=64 one cycle after beat 7, then 64 every 8 cycles.
REQ-036 Bench SHALL cover data=-3 and weights=5, IN_DEPTH=2, PARALLELISM=4: data_out=-120 (0xFF...88 sign-extended).
REQ-037 Bench SHALL cover data_out_ready held low for 5 cycles after a result: data_out is stable, both input readys are 0, and no beats are lost after release.
REQ-038 Bench SHALL cover weight_valid toggling randomly with data_in_valid high: neither stream is consumed alone, and the sum matches the reference model.
REQ-039 Bench SHALL cover rst pulsed low after beat 4 of 8: data_out_valid=0, and the next result sums only beats 0-7 issued after release.
REQ-040 Bench SHALL cover DATA_OUT_PRECISION_0=8, data=127, weights=127, PARALLELISM=1, IN_DEPTH=1: output is 127 with the macro defined and 0x01 (wrapped) without it.

Source files
------------

// File: rtl/linear_dot_accumulator.sv
// Dot-product accumulator over IN_DEPTH beats of PARALLELISM-wide vectors; define LINEAR_DOT_ACCUMULATOR_SATURATE_EN to clamp the result instead of wrapping it.
// Latency: data_out_valid rises one clock after the last beat of a group is consumed.
// Backpressure: beats are taken only when both streams are valid and the output register is empty or draining.
module linear_dot_accumulator #(
    parameter int DATA_IN_PRECISION_0  = 16,
    parameter int DATA_IN_PRECISION_1  = 3,
    parameter int WEIGHT_PRECISION_0   = 16,
    parameter int WEIGHT_PRECISION_1   = 3,
    parameter int PARALLELISM          = 4,
    parameter int IN_DEPTH             = 8,
    parameter int DATA_OUT_PRECISION_0 = DATA_IN_PRECISION_0 + WEIGHT_PRECISION_0
                                         + $clog2(PARALLELISM * IN_DEPTH)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [DATA_IN_PRECISION_0-1:0]         data_in [PARALLELISM],
    input  logic                                   data_in_valid,
    output logic                                   data_in_ready,
    input  logic [WEIGHT_PRECISION_0-1:0]          weight [PARALLELISM],
    input  logic                                   weight_valid,
    output logic                                   weight_ready,
    output logic signed [DATA_OUT_PRECISION_0-1:0] data_out,
    output logic                                   data_out_valid,
    input  logic                                   data_out_ready
);

    localparam int DIN_W  = DATA_IN_PRECISION_0;
    localparam int WGT_W  = WEIGHT_PRECISION_0;
    localparam int DOUT_W = DATA_OUT_PRECISION_0;
    localparam int PROD_W = DIN_W + WGT_W;
    // One spare bit above the exact worst-case growth keeps the running sum overflow-free.
    localparam int SUM_W  = PROD_W + $clog2(PARALLELISM * IN_DEPTH) + 1;
    localparam int ACC_W  = (SUM_W > DOUT_W) ? SUM_W : DOUT_W;
    localparam int CNT_W  = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(IN_DEPTH - 1);

    if (IN_DEPTH < 1 || PARALLELISM < 1 ||
        DATA_IN_PRECISION_1 >= DATA_IN_PRECISION_0 ||
        WEIGHT_PRECISION_1 >= WEIGHT_PRECISION_0) begin : g_bad_cfg
        $error("linear_dot_accumulator: illegal parameter combination");
    end

    logic                    accept;
    logic                    fire;
    logic                    last;
    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] prod_ext [PARALLELISM];
    logic signed [ACC_W-1:0] beat_sum;
    logic signed [ACC_W-1:0] final_sum;
    logic [DOUT_W-1:0]       result;

    assign accept        = rst && (!data_out_valid || data_out_ready);
    assign data_in_ready = weight_valid && accept;
    assign weight_ready  = data_in_valid && accept;
    assign fire          = data_in_valid && weight_valid && accept;
    assign last          = (cnt == LAST_BEAT);

    for (genvar g = 0; g < PARALLELISM; g++) begin : g_lane
        logic signed [PROD_W-1:0] op_a;
        logic signed [PROD_W-1:0] op_b;
        logic signed [PROD_W-1:0] prod;

        assign op_a = {{WGT_W{data_in[g][DIN_W-1]}}, data_in[g]};
        assign op_b = {{DIN_W{weight[g][WGT_W-1]}}, weight[g]};
        assign prod = op_a * op_b;
        if (ACC_W > PROD_W) begin : g_ext
            assign prod_ext[g] = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        end else begin : g_noext
            assign prod_ext[g] = prod;
        end
    end

    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < PARALLELISM; i++) begin
            beat_sum = beat_sum + prod_ext[i];
        end
    end

    assign final_sum = acc + beat_sum;

`ifdef LINEAR_DOT_ACCUMULATOR_SATURATE_EN
    localparam logic signed [ACC_W-1:0] OUT_MAX = {1'b0, {(ACC_W-1){1'b1}}} >> (ACC_W - DOUT_W);
    localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

    always_comb begin
        result = final_sum[DOUT_W-1:0];
        if (final_sum > OUT_MAX) begin
            result = OUT_MAX[DOUT_W-1:0];
        end else if (final_sum < OUT_MIN) begin
            result = OUT_MIN[DOUT_W-1:0];
        end
    end
`else
    assign result = final_sum[DOUT_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt            <= '0;
            acc            <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            if (fire) begin
                if (last) begin
                    cnt      <= '0;
                    acc      <= '0;
                    data_out <= result;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                    acc <= final_sum;
                end
            end
            // A new result landing in the same cycle as a pop keeps the output valid.
            if (fire && last) begin
                data_out_valid <= 1'b1;
            end else if (data_out_ready) begin
                data_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_linear_dot_accumulator.sv
// Bench for linear_dot_accumulator: directed steps plus randomized streams scored against a transaction-level model.
module tb_linear_dot_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // default configuration instance
    logic [15:0]        a_din [4];
    logic [15:0]        a_w   [4];
    logic               a_div, a_dir, a_wv, a_wr, a_dov, a_dor;
    logic signed [36:0] a_dout;

    // IN_DEPTH=2 instance
    logic [15:0]        b_din [4];
    logic [15:0]        b_w   [4];
    logic               b_div, b_dir, b_wv, b_wr, b_dov, b_dor;
    logic signed [34:0] b_dout;

    // narrow-output, single-beat instance
    logic [15:0]        c_din [1];
    logic [15:0]        c_w   [1];
    logic               c_div, c_dir, c_wv, c_wr, c_dov, c_dor;
    logic signed [7:0]  c_dout;

    int n_tests = 0;
    int n_fail  = 0;

    linear_dot_accumulator u_main (
        .clk(clk), .rst(rst),
        .data_in(a_din), .data_in_valid(a_div), .data_in_ready(a_dir),
        .weight(a_w), .weight_valid(a_wv), .weight_ready(a_wr),
        .data_out(a_dout), .data_out_valid(a_dov), .data_out_ready(a_dor)
    );

    linear_dot_accumulator #(.IN_DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst),
        .data_in(b_din), .data_in_valid(b_div), .data_in_ready(b_dir),
        .weight(b_w), .weight_valid(b_wv), .weight_ready(b_wr),
        .data_out(b_dout), .data_out_valid(b_dov), .data_out_ready(b_dor)
    );

    linear_dot_accumulator #(.PARALLELISM(1), .IN_DEPTH(1), .DATA_OUT_PRECISION_0(8)) u_sm (
        .clk(clk), .rst(rst),
        .data_in(c_din), .data_in_valid(c_div), .data_in_ready(c_dir),
        .weight(c_w), .weight_valid(c_wv), .weight_ready(c_wr),
        .data_out(c_dout), .data_out_valid(c_dov), .data_out_ready(c_dor)
    );

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic [15:0] d, input logic [15:0] w);
        for (int i = 0; i < 4; i++) begin
            a_din[i] = d;
            a_w[i]   = w;
        end
    endtask

    // Reference model for u_main: beats land in a queue, each full group of 8 becomes one result.
    longint m_beats[$];
    longint m_dout;
    logic   m_dov;
    logic   m_accept;
    longint m_s;

    always @(negedge clk) begin
        if (!rst) begin
            m_beats.delete();
            m_dov = 1'b0;
            check("rst_data_in_ready", a_dir, 0);
            check("rst_weight_ready", a_wr, 0);
            check("rst_data_out_valid", a_dov, 0);
        end else begin
            check("data_out_valid", a_dov, m_dov);
            if (m_dov) check("data_out", a_dout, m_dout);
            m_accept = !m_dov || a_dor;
            check("data_in_ready", a_dir, a_wv && m_accept);
            check("weight_ready", a_wr, a_div && m_accept);
            if (a_div && a_wv && m_accept) begin
                m_s = 0;
                for (int i = 0; i < 4; i++)
                    m_s += longint'($signed(a_din[i])) * longint'($signed(a_w[i]));
                m_beats.push_back(m_s);
            end
            if (m_beats.size() == 8) begin
                m_dout = 0;
                foreach (m_beats[k]) m_dout += m_beats[k];
                m_beats.delete();
                m_dov = 1'b1;
            end else if (a_dor) begin
                m_dov = 1'b0;
            end
        end
    end

    initial begin
        rst = 1'b0;
        set_a(16'd1, 16'd2);
        a_div = 1'b1; a_wv = 1'b1; a_dor = 1'b1;
        for (int i = 0; i < 4; i++) begin b_din[i] = '0; b_w[i] = '0; end
        b_div = 1'b0; b_wv = 1'b0; b_dor = 1'b1;
        c_din[0] = '0; c_w[0] = '0;
        c_div = 1'b0; c_wv = 1'b0; c_dor = 1'b1;

        // reset state, with valids high to show the readys are forced low
        tick();
        check("reset_data_out", a_dout, 0);
        check("reset_data_out_valid", a_dov, 0);
        check("reset_data_in_ready", a_dir, 0);
        check("reset_weight_ready", a_wr, 0);
        check("reset_d2_valid", b_dov, 0);
        check("reset_sm_valid", c_dov, 0);

        // data=1, weights=2 streaming: 64 after beat 7, then every 8 cycles
        rst = 1'b1;
        repeat (7) tick();
        check("stream_before_last", a_dov, 0);
        tick();
        check("stream_first_valid", a_dov, 1);
        check("stream_first_value", a_dout, 64);
        tick();
        check("stream_valid_clears", a_dov, 0);
        repeat (7) tick();
        check("stream_second_valid", a_dov, 1);
        check("stream_second_value", a_dout, 64);

        // output stall for 5 cycles
        a_dor = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_value", a_dout, 64);
            check("stall_valid", a_dov, 1);
            check("stall_data_in_ready", a_dir, 0);
            check("stall_weight_ready", a_wr, 0);
        end
        a_dor = 1'b1;
        repeat (7) tick();
        check("post_stall_not_early", a_dov, 0);
        tick();
        check("post_stall_valid", a_dov, 1);
        check("post_stall_value", a_dout, 64);

        // random data, toggling weight_valid and data_out_ready
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                a_din[i] = 16'($urandom);
                a_w[i]   = 16'($urandom);
            end
            a_div = 1'b1;
            a_wv  = 1'($urandom_range(0, 1));
            a_dor = ($urandom_range(0, 3) != 0);
            tick();
        end

        // reset mid-accumulation after 4 of 8 beats
        a_div = 1'b0; a_wv = 1'b0; a_dor = 1'b1;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        set_a(16'd100, 16'd100);
        a_div = 1'b1; a_wv = 1'b1;
        repeat (4) tick();
        rst = 1'b0;
        #1;
        check("midrst_valid", a_dov, 0);
        check("midrst_data_in_ready", a_dir, 0);
        check("midrst_weight_ready", a_wr, 0);
        tick();
        rst = 1'b1;
        set_a(16'd1, 16'd2);
        repeat (7) tick();
        check("midrst_not_early", a_dov, 0);
        tick();
        a_div = 1'b0; a_wv = 1'b0;
        check("midrst_result_valid", a_dov, 1);
        check("midrst_result_value", a_dout, 64);

        // IN_DEPTH=2, data=-3, weights=5
        for (int i = 0; i < 4; i++) begin b_din[i] = 16'hFFFD; b_w[i] = 16'd5; end
        b_div = 1'b1; b_wv = 1'b1;
        tick();
        check("d2_after_beat0", b_dov, 0);
        tick();
        b_div = 1'b0; b_wv = 1'b0;
        check("d2_valid", b_dov, 1);
        check("d2_value", b_dout, -120);
        tick();
        check("d2_valid_clears", b_dov, 0);

        // narrow output, one beat per result
        c_din[0] = 16'd127; c_w[0] = 16'd127;
        c_div = 1'b1; c_wv = 1'b1;
        tick();
        check("sm_first_valid", c_dov, 1);
`ifdef LINEAR_DOT_ACCUMULATOR_SATURATE_EN
        check("sm_pos_value", c_dout, 127);
`else
        check("sm_pos_value", c_dout, 1);
`endif
        c_din[0] = 16'hFF81;
        tick();
        c_div = 1'b0; c_wv = 1'b0;
        check("sm_back_to_back_valid", c_dov, 1);
`ifdef LINEAR_DOT_ACCUMULATOR_SATURATE_EN
        check("sm_neg_value", c_dout, -128);
`else
        check("sm_neg_value", c_dout, -1);
`endif
        tick();
        check("sm_valid_clears", c_dov, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
